// File: rtl/pd_sample_sequencer.sv
// Samples the asynchronous TDL phase detector in the fpga_clk domain, averages
// 2**LOG2_AVG error samples and offers each average to the loop filter.
module pd_sample_sequencer #(
   parameter int WIDTH       = 5,
   parameter int LOG2_AVG    = 2,
   parameter int SETTLE_CYC  = 3,
   parameter int TIMEOUT_CYC = 1023,
   parameter int LOCK_THRESH = 1,
   parameter int LOCK_COUNT  = 4
) (
   input  logic             fpga_clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic             pd_done_i,
   input  logic [WIDTH-1:0] pd_error_i,
   output logic [WIDTH-1:0] err_o,
   output logic             err_valid_o,
   input  logic             err_ready_i,
   output logic             locked_o,
   output logic             overrun_o,
   output logic             timeout_o
);

   localparam int ACC_W  = WIDTH + LOG2_AVG;
   localparam int N_W    = LOG2_AVG + 1;
   localparam int TMAX   = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
   localparam int TMR_W  = $clog2(TMAX + 1);
   localparam int LCNT_W = $clog2(LOCK_COUNT + 1);
   localparam logic [N_W-1:0] N_LAST = N_W'((1 << LOG2_AVG) - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_SETTLE  = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              sync_q, sync_d;
   logic [TMR_W-1:0]        timer_q, timer_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [N_W-1:0]          n_q, n_d;
   logic                    emit_q, emit_d;
   logic [WIDTH-1:0]        err_q, err_d;
   logic                    valid_q, valid_d;
   logic                    locked_q, locked_d;
   logic                    overrun_q, overrun_d;
   logic                    timeout_q, timeout_d;
   logic [LCNT_W-1:0]       lcnt_q, lcnt_d;

   logic                    edge_s;
   logic signed [ACC_W-1:0] sample_s;
   logic [WIDTH-1:0]        avg_s;
   logic [WIDTH:0]          avg_ext_s;
   logic [WIDTH:0]          avg_abs_s;
   logic                    in_lock_s;
   logic [LCNT_W-1:0]       lcnt_inc_s;

   assign edge_s     = sync_q[1] & ~sync_q[2];
   assign sample_s   = ACC_W'($signed(pd_error_i));
   assign avg_s      = WIDTH'(acc_q >>> LOG2_AVG);
   // One extra bit so the magnitude of the most negative average is representable.
   assign avg_ext_s  = {avg_s[WIDTH-1], avg_s};
   assign avg_abs_s  = avg_ext_s[WIDTH] ? (~avg_ext_s + (WIDTH+1)'(1)) : avg_ext_s;
   assign in_lock_s  = (avg_abs_s <= (WIDTH+1)'(LOCK_THRESH));
   assign lcnt_inc_s = (lcnt_q == LCNT_W'(LOCK_COUNT)) ? lcnt_q : lcnt_q + LCNT_W'(1);

   // Next-state logic for the sequencer, the averager and the output handshake.
   always_comb begin
      sync_d    = {sync_q[1:0], pd_done_i};
      state_d   = state_q;
      timer_d   = timer_q;
      acc_d     = acc_q;
      n_d       = n_q;
      emit_d    = 1'b0;
      err_d     = err_q;
      valid_d   = valid_q;
      locked_d  = locked_q;
      lcnt_d    = lcnt_q;
      overrun_d = overrun_q;
      timeout_d = timeout_q;

      if (!enable_i) begin
         state_d  = ST_IDLE;
         timer_d  = {TMR_W{1'b0}};
         acc_d    = {ACC_W{1'b0}};
         n_d      = {N_W{1'b0}};
         valid_d  = 1'b0;
         locked_d = 1'b0;
         lcnt_d   = {LCNT_W{1'b0}};
      end else begin
         // The average completed by last cycle's capture is presented here.
         if (emit_q) begin
            err_d   = avg_s;
            valid_d = 1'b1;
            acc_d   = {ACC_W{1'b0}};
            n_d     = {N_W{1'b0}};
            if (valid_q && !err_ready_i) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
            if (in_lock_s) begin
               lcnt_d   = lcnt_inc_s;
               locked_d = (lcnt_inc_s == LCNT_W'(LOCK_COUNT));
            end else begin
               lcnt_d   = {LCNT_W{1'b0}};
               locked_d = 1'b0;
            end
         end else if (valid_q && err_ready_i) begin
            valid_d = 1'b0;
         end else begin
            valid_d = valid_q;
         end

         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARMED;
               timer_d = {TMR_W{1'b0}};
               acc_d   = {ACC_W{1'b0}};
               n_d     = {N_W{1'b0}};
            end
            ST_ARMED: begin
               if (edge_s) begin
                  state_d = ST_SETTLE;
                  timer_d = {TMR_W{1'b0}};
               end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
                  lcnt_d    = {LCNT_W{1'b0}};
                  timer_d   = {TMR_W{1'b0}};
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            ST_SETTLE: begin
               if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
                  state_d = ST_CAPTURE;
                  timer_d = {TMR_W{1'b0}};
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            ST_CAPTURE: begin
               acc_d   = acc_q + sample_s;
               n_d     = n_q + N_W'(1);
               emit_d  = (n_q == N_LAST);
               state_d = ST_ARMED;
               timer_d = {TMR_W{1'b0}};
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge fpga_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         sync_q    <= 3'b000;
         timer_q   <= {TMR_W{1'b0}};
         acc_q     <= {ACC_W{1'b0}};
         n_q       <= {N_W{1'b0}};
         emit_q    <= 1'b0;
         err_q     <= {WIDTH{1'b0}};
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         lcnt_q    <= {LCNT_W{1'b0}};
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         timer_q   <= timer_d;
         acc_q     <= acc_d;
         n_q       <= n_d;
         emit_q    <= emit_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         lcnt_q    <= lcnt_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

   assign err_o       = err_q;
   assign err_valid_o = valid_q;
   assign locked_o    = locked_q;
   assign overrun_o   = overrun_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pd_sample_sequencer.sv
// Bench for pd_sample_sequencer: directed scenarios plus a random schedule, all
// checked cycle by cycle against a timeline model of strobes, samples and emits.
module tb_pd_sample_sequencer;

   localparam int WIDTH       = 5;
   localparam int LOG2_AVG    = 2;
   localparam int SETTLE_CYC  = 3;
   localparam int TIMEOUT_CYC = 1023;
   localparam int LOCK_THRESH = 1;
   localparam int LOCK_COUNT  = 4;
   localparam int NAVG        = 1 << LOG2_AVG;
   localparam int MAXC        = 1300;

   logic             clk = 1'b0;
   logic             reset_i;
   logic             enable_i;
   logic             pd_done_i;
   logic [WIDTH-1:0] pd_error_i;
   logic [WIDTH-1:0] err_o;
   logic             err_valid_o;
   logic             err_ready_i;
   logic             locked_o;
   logic             overrun_o;
   logic             timeout_o;

   always #5 clk = ~clk;

   pd_sample_sequencer #(
      .WIDTH(WIDTH), .LOG2_AVG(LOG2_AVG), .SETTLE_CYC(SETTLE_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC), .LOCK_THRESH(LOCK_THRESH), .LOCK_COUNT(LOCK_COUNT)
   ) dut (
      .fpga_clk_i (clk),
      .reset_i    (reset_i),
      .enable_i   (enable_i),
      .pd_done_i  (pd_done_i),
      .pd_error_i (pd_error_i),
      .err_o      (err_o),
      .err_valid_o(err_valid_o),
      .err_ready_i(err_ready_i),
      .locked_o   (locked_o),
      .overrun_o  (overrun_o),
      .timeout_o  (timeout_o)
   );

   int n_vec = 0;
   int n_bad = 0;

   bit en_s   [MAXC];
   bit done_s [MAXC];
   int perr_s [MAXC];
   bit rdy_s  [MAXC];

   int accepted[$];
   int locked_seen;
   int tout_cyc;

   task automatic check_eq(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic bit done_at(input int i);
      return (i >= 0) ? done_s[i] : 1'b0;
   endfunction

   task automatic clear_sched();
      for (int t = 0; t < MAXC; t++) begin
         en_s[t]   = 1'b0;
         done_s[t] = 1'b0;
         perr_s[t] = 0;
         rdy_s[t]  = 1'b1;
      end
   endtask

   task automatic set_en(input int from, input int to);
      for (int t = from; t < to; t++) en_s[t] = 1'b1;
   endtask

   task automatic set_rdy(input int from, input int to, input bit v);
      for (int t = from; t < to; t++) rdy_s[t] = v;
   endtask

   // A detector result: done pulses for one cycle, error held until the next result.
   task automatic strobe(input int t, input int e);
      done_s[t] = 1'b1;
      for (int i = t; i < MAXC; i++) perr_s[i] = e;
   endtask

   task automatic run_sched(input string name, input int len);
      int  samples[$];
      int  cap_at, emit_at, emit_val, next_accept, arm_start, lcnt, sum, q;
      bit  m_valid, m_locked, m_overrun, m_timeout, edg, prev_valid;
      int  m_err, prev_err;

      @(negedge clk);
      reset_i = 1'b1; enable_i = 1'b0; pd_done_i = 1'b0; pd_error_i = '0; err_ready_i = 1'b0;
      @(negedge clk);
      reset_i = 1'b0;
      accepted.delete();
      locked_seen = 0; tout_cyc = -1;
      cap_at = -1; emit_at = -1; emit_val = 0; next_accept = 1; arm_start = 1; lcnt = 0;
      m_valid = 0; m_locked = 0; m_overrun = 0; m_timeout = 0; m_err = 0;
      prev_valid = 0; prev_err = 0;

      for (int t = 0; t < len; t++) begin
         enable_i    = en_s[t];
         pd_done_i   = done_s[t];
         pd_error_i  = WIDTH'(perr_s[t]);
         err_ready_i = rdy_s[t];
         @(posedge clk);
         #1;
         if (prev_valid && rdy_s[t]) accepted.push_back(prev_err);

         if (!en_s[t]) begin
            samples.delete();
            cap_at = -1; emit_at = -1;
            m_valid = 0; m_locked = 0; lcnt = 0;
            next_accept = t + 2; arm_start = t + 2;
         end else begin
            if (emit_at == t) begin
               if (m_valid && !rdy_s[t]) m_overrun = 1;
               m_valid = 1; m_err = emit_val;
               if (iabs(emit_val) <= LOCK_THRESH) begin
                  if (lcnt < LOCK_COUNT) lcnt++;
                  m_locked = (lcnt == LOCK_COUNT);
               end else begin
                  lcnt = 0; m_locked = 0;
               end
               emit_at = -1;
            end else if (m_valid && rdy_s[t]) begin
               m_valid = 0;
            end
            if (cap_at == t) begin
               samples.push_back(perr_s[t]);
               cap_at = -1;
               if (samples.size() == NAVG) begin
                  sum = 0;
                  foreach (samples[i]) sum += samples[i];
                  q = sum / NAVG;
                  if ((sum % NAVG) != 0 && sum < 0) q = q - 1;
                  emit_val = q; emit_at = t + 1;
                  samples.delete();
               end
            end
            edg = done_at(t - 2) && !done_at(t - 3);
            if (t >= next_accept) begin
               if (edg) begin
                  cap_at = t + SETTLE_CYC + 1;
                  next_accept = t + SETTLE_CYC + 2;
                  arm_start = next_accept;
               end else if (t - arm_start == TIMEOUT_CYC - 1) begin
                  m_timeout = 1; m_locked = 0; lcnt = 0;
                  arm_start = t + 1;
               end
            end
         end

         check_eq($sformatf("%s.valid@%0d", name, t), err_valid_o, m_valid);
         if (m_valid) check_eq($sformatf("%s.err@%0d", name, t), $signed(err_o), m_err);
         check_eq($sformatf("%s.locked@%0d", name, t), locked_o, m_locked);
         check_eq($sformatf("%s.overrun@%0d", name, t), overrun_o, m_overrun);
         check_eq($sformatf("%s.timeout@%0d", name, t), timeout_o, m_timeout);

         prev_valid = err_valid_o;
         prev_err   = $signed(err_o);
         if (locked_o) locked_seen = 1;
         if (timeout_o && tout_cyc < 0) tout_cyc = t;
         @(negedge clk);
      end
   endtask

   initial begin
      reset_i = 1'b1; enable_i = 1'b0; pd_done_i = 1'b0; pd_error_i = '0; err_ready_i = 1'b0;

      // T1: two averages, the second one rounding toward minus infinity.
      clear_sched(); set_en(2, 95);
      for (int i = 0; i < 4; i++) strobe(5 + 10 * i, 3);
      strobe(45, -1); strobe(55, -2); strobe(65, -1); strobe(75, -2);
      run_sched("t1", 95);
      check_eq("t1_count", accepted.size(), 2);
      if (accepted.size() == 2) begin
         check_eq("t1_avg0", accepted[0], 3);
         check_eq("t1_avg1", accepted[1], -2);
      end

      // T2: averages 0,1,-1,1 reach lock, then 2 drops it.
      clear_sched(); set_en(2, 215);
      for (int i = 0; i < 20; i++) begin
         int v;
         case (i / 4)
            0: v = 0;
            1: v = 1;
            2: v = -1;
            3: v = 1;
            default: v = 2;
         endcase
         strobe(5 + 10 * i, v);
      end
      run_sched("t2", 215);
      check_eq("t2_count", accepted.size(), 5);
      check_eq("t2_lock_seen", locked_seen, 1);
      check_eq("t2_lock_end", locked_o, 0);

      // T3: no ready across two emits.
      clear_sched(); set_en(2, 100); set_rdy(0, 100, 1'b0);
      for (int i = 0; i < 8; i++) strobe(5 + 10 * i, (i < 4) ? 5 : 6);
      run_sched("t3", 100);
      check_eq("t3_err", $signed(err_o), 6);
      check_eq("t3_valid", err_valid_o, 1);
      check_eq("t3_overrun", overrun_o, 1);

      // T4: lock, then strobes stop until the ARMED timeout.
      clear_sched(); set_en(2, 1200);
      for (int i = 0; i < 16; i++) strobe(5 + 10 * i, 0);
      run_sched("t4", 1200);
      check_eq("t4_lock_seen", locked_seen, 1);
      check_eq("t4_tout_cyc", tout_cyc, 1184);
      check_eq("t4_timeout", timeout_o, 1);
      check_eq("t4_locked", locked_o, 0);

      // T5: partial set dropped by a one-cycle disable, then reset during SETTLE.
      clear_sched(); set_en(2, 90); en_s[25] = 1'b0; set_rdy(0, 90, 1'b0);
      strobe(5, 7); strobe(15, 7);
      for (int i = 0; i < 4; i++) strobe(35 + 10 * i, 4);
      run_sched("t5", 90);
      check_eq("t5_err", $signed(err_o), 4);
      check_eq("t5_valid", err_valid_o, 1);
      check_eq("t5_overrun", overrun_o, 0);
      pd_done_i = 1'b1;
      @(negedge clk);
      pd_done_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 reset_i = 1'b1;
      #1;
      check_eq("t5_rst_err", err_o, 0);
      check_eq("t5_rst_valid", err_valid_o, 0);
      check_eq("t5_rst_locked", locked_o, 0);
      check_eq("t5_rst_overrun", overrun_o, 0);
      check_eq("t5_rst_timeout", timeout_o, 0);

      // T6: strobes inside the settle window are dropped.
      clear_sched(); set_en(2, 100);
      for (int i = 0; i < 8; i++) strobe(5 + 10 * i, 2);
      done_s[7] = 1'b1; done_s[18] = 1'b1; done_s[29] = 1'b1; done_s[49] = 1'b1;
      run_sched("t6", 100);
      check_eq("t6_count", accepted.size(), 2);

      // Random schedule: strobe spacing, errors, ready and short disables.
      clear_sched(); set_en(2, 800);
      for (int t = 100; t < 790; t++)
         if ($urandom_range(0, 149) == 0)
            for (int k = 0; k <= int'($urandom_range(0, 2)); k++) en_s[t + k] = 1'b0;
      for (int t = 0; t < 800; t++) rdy_s[t] = ($urandom_range(0, 3) != 0);
      begin
         int t = 4;
         while (t < 790) begin
            if ($urandom_range(0, 1) == 0) strobe(t, int'($urandom_range(0, 4)) - 2);
            else strobe(t, int'($urandom_range(0, 31)) - 16);
            t += int'($urandom_range(2, 9));
         end
      end
      run_sched("rnd", 800);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
